// File: rtl/bg_pkg.sv
// Shared types and width constants for the BG tile pixel fetch path.
package bg_pkg;

   localparam int VRAM_ADDR_W = 16;
   localparam int VRAM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } bg_fetch_state_t;

endpackage

// File: rtl/bg_pixel_extract.sv
// Byte/nibble select from a VRAM halfword and palette index/transparency generation.
module bg_pixel_extract
   import bg_pkg::*;
(
   input  logic [VRAM_DATA_W-1:0] hw,
   input  logic                   byte_sel,
   input  logic                   palettemode,
   input  logic                   nibble_sel,
   input  logic [3:0]             palbank,
   output logic [7:0]             index,
   output logic                   transparent
);

   logic [7:0] sel_byte;
   logic [3:0] nib;

   always_comb begin
      sel_byte = byte_sel ? hw[15:8] : hw[7:0];
      nib      = nibble_sel ? sel_byte[7:4] : sel_byte[3:0];
      if (palettemode) begin
         index       = sel_byte;
         transparent = (sel_byte == 8'h00);
      end else begin
         index       = {palbank, nib};
         transparent = (nib == 4'h0);
      end
   end

endmodule

// File: rtl/bg_tile_pixel_fetch.sv
// BG character pixel fetch: VRAM halfword read, FSM and optional one-entry
// halfword cache (enabled by defining BG_FETCH_CACHE_EN).
module bg_tile_pixel_fetch
   import bg_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
)
(
   input  logic              clock,
   input  logic              reset_N,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_palettemode,
   input  logic              in_nibble_sel,
   input  logic [3:0]        in_palbank,
   output logic              vram_req,
   output logic [ADDR_W-2:0] vram_addr,
   input  logic              vram_gnt,
   input  logic              vram_rvalid,
   input  logic [DATA_W-1:0] vram_rdata,
   input  logic              cache_flush,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [7:0]        pix_index,
   output logic              pix_transparent
);

   bg_fetch_state_t   state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              mode_reg;
   logic              nib_reg;
   logic [3:0]        bank_reg;
   logic [DATA_W-1:0] hw_reg;
   logic              cache_hit;
   logic              accept;
   logic              rd_done;
   logic [7:0]        ext_index;
   logic              ext_transparent;

   assign accept  = in_ready && in_valid;
   assign rd_done = (state_reg == WAIT) && vram_rvalid;

`ifdef BG_FETCH_CACHE_EN
   logic [ADDR_W-2:0] tag_reg;
   logic              tag_valid_reg;
   logic              flush_pend_reg;

   assign cache_hit = tag_valid_reg && (tag_reg == in_addr[ADDR_W-1:1]) && !cache_flush;

   // A flush seen while the read is in flight still lets this pixel use the
   // returned data, but keeps the new tag from being marked valid.
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         tag_reg        <= '0;
         tag_valid_reg  <= 1'b0;
         flush_pend_reg <= 1'b0;
      end else if (rd_done) begin
         tag_reg        <= addr_reg[ADDR_W-1:1];
         tag_valid_reg  <= !(flush_pend_reg || cache_flush);
         flush_pend_reg <= 1'b0;
      end else if (cache_flush) begin
         tag_valid_reg <= 1'b0;
         if (state_reg == REQ || state_reg == WAIT)
            flush_pend_reg <= 1'b1;
      end
   end
`else
   logic unused_cache_flush;
   assign unused_cache_flush = cache_flush;
   assign cache_hit          = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         mode_reg  <= 1'b0;
         nib_reg   <= 1'b0;
         bank_reg  <= '0;
         hw_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg <= in_addr;
            mode_reg <= in_palettemode;
            nib_reg  <= in_nibble_sel;
            bank_reg <= in_palbank;
         end
         if (rd_done)
            hw_reg <= vram_rdata;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      vram_req   = 1'b0;
      pix_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = reset_N;
            if (accept)
               state_next = cache_hit ? OUT : REQ;
         end
         REQ: begin
            vram_req = 1'b1;
            if (vram_gnt)
               state_next = WAIT;
         end
         WAIT: begin
            if (vram_rvalid)
               state_next = OUT;
         end
         OUT: begin
            pix_valid = 1'b1;
            if (pix_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   bg_pixel_extract u_extract (
      .hw          (hw_reg),
      .byte_sel    (addr_reg[0]),
      .palettemode (mode_reg),
      .nibble_sel  (nib_reg),
      .palbank     (bank_reg),
      .index       (ext_index),
      .transparent (ext_transparent)
   );

   assign vram_addr       = addr_reg[ADDR_W-1:1];
   assign pix_index       = pix_valid ? ext_index : 8'h00;
   assign pix_transparent = pix_valid && ext_transparent;

endmodule

// File: tb/tb_bg_tile_pixel_fetch.sv
// Self-checking bench for bg_tile_pixel_fetch (adapts hit expectations to BG_FETCH_CACHE_EN).
module tb_bg_tile_pixel_fetch;

`ifdef BG_FETCH_CACHE_EN
   localparam bit CACHE_ON = 1'b1;
`else
   localparam bit CACHE_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_N = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_addr = '0;
   logic        in_palettemode = 1'b0;
   logic        in_nibble_sel = 1'b0;
   logic [3:0]  in_palbank = '0;
   logic        vram_req;
   logic [14:0] vram_addr;
   logic        vram_gnt = 1'b0;
   logic        vram_rvalid = 1'b0;
   logic [15:0] vram_rdata = 16'hDEAD;
   logic        cache_flush = 1'b0;
   logic        pix_valid;
   logic        pix_ready = 1'b0;
   logic [7:0]  pix_index;
   logic        pix_transparent;

   always #5 clock = ~clock;

   bg_tile_pixel_fetch dut (
      .clock           (clock),
      .reset_N         (reset_N),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_addr         (in_addr),
      .in_palettemode  (in_palettemode),
      .in_nibble_sel   (in_nibble_sel),
      .in_palbank      (in_palbank),
      .vram_req        (vram_req),
      .vram_addr       (vram_addr),
      .vram_gnt        (vram_gnt),
      .vram_rvalid     (vram_rvalid),
      .vram_rdata      (vram_rdata),
      .cache_flush     (cache_flush),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_index       (pix_index),
      .pix_transparent (pix_transparent)
   );

   typedef struct {
      logic [15:0] addr;
      logic        mode;
      logic        nib;
      logic [3:0]  bank;
      logic [15:0] rdata;
      int          gnt_dly;
      int          rv_dly;
      int          rdy_dly;
      logic        flush_acc;
      logic        flush_mid;
      logic        hit;
      logic [7:0]  exp_index;
      logic        exp_tr;
   } vec_t;

   typedef struct {
      logic [7:0] index;
      logic       tr;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[11];
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic run_txn(input int id, input vec_t v);
      int   cyc;
      int   gcnt;
      int   rcnt;
      bit   got_req;
      bit   in_wait;
      bit   gnt_now;
      exp_t e;
      exp_q.push_back('{index: v.exp_index, tr: v.exp_tr});
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid       = 1'b1;
      in_addr        = v.addr;
      in_palettemode = v.mode;
      in_nibble_sel  = v.nib;
      in_palbank     = v.bank;
      cache_flush    = v.flush_acc;
      step();
      in_valid       = 1'b0;
      cache_flush    = 1'b0;
      in_addr        = 16'($urandom);
      in_palettemode = 1'($urandom);
      in_nibble_sel  = 1'($urandom);
      in_palbank     = 4'($urandom);
      cyc = 1; gcnt = 0; rcnt = 0; got_req = 0; in_wait = 0;
      while (!pix_valid && cyc < 60) begin
         gnt_now = 0;
         if (vram_req) begin
            got_req = 1;
            chk("vram_addr", {17'd0, vram_addr}, {17'd0, v.addr[15:1]});
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            gnt_now     = (gcnt == v.gnt_dly);
            cache_flush = v.flush_mid && (gcnt == 0);
            gcnt++;
         end else if (in_wait) begin
            vram_rvalid = (rcnt == v.rv_dly);
            vram_rdata  = vram_rvalid ? v.rdata : 16'hDEAD;
            rcnt++;
         end
         vram_gnt = gnt_now;
         step();
         vram_gnt    = 1'b0;
         vram_rvalid = 1'b0;
         vram_rdata  = 16'hDEAD;
         cache_flush = 1'b0;
         if (gnt_now) in_wait = 1;
         cyc++;
      end
      if (!pix_valid) begin
         n_checks++;
         $display("FAIL txn%0d_timeout: pix_valid still 0 after %0d cycles, required 1", id, cyc);
         void'(exp_q.pop_front());
         return;
      end
      chk("latency", cyc, v.hit ? 1 : 3 + v.gnt_dly + v.rv_dly);
      chk("vram_req_seen", {31'd0, got_req}, {31'd0, !v.hit});
      e = exp_q[0];
      for (int i = 0; i < v.rdy_dly; i++) begin
         chk("hold_valid", {31'd0, pix_valid}, 32'd1);
         chk("hold_index", {24'd0, pix_index}, {24'd0, e.index});
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         step();
      end
      pix_ready = 1'b1;
      e = exp_q.pop_front();
      chk("pix_index", {24'd0, pix_index}, {24'd0, e.index});
      chk("pix_transparent", {31'd0, pix_transparent}, {31'd0, e.tr});
      $display("txn %0d addr=0x%04h mode=%0d hit=%0d latency=%0d index=0x%02h transparent=%0d",
               id, v.addr, v.mode, v.hit, cyc, pix_index, pix_transparent);
      step();
      pix_ready = 1'b0;
      chk("post_valid", {31'd0, pix_valid}, 32'd0);
      chk("post_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      vec_t vr;
      //          addr     mode  nib   bank  rdata     g  r  rdy flush_acc flush_mid hit       index  tr
      vecs[0]  = '{16'h4003, 1'b0, 1'b1, 4'h5, 16'hA7C0, 0, 0, 0, 1'b0, 1'b0, 1'b0,     8'h5A, 1'b0};
      vecs[1]  = '{16'h4002, 1'b0, 1'b1, 4'h5, 16'hA7C0, 0, 0, 0, 1'b0, 1'b0, CACHE_ON, 8'h5C, 1'b0};
      vecs[2]  = '{16'h0010, 1'b1, 1'b0, 4'h0, 16'h3300, 0, 0, 0, 1'b0, 1'b0, 1'b0,     8'h00, 1'b1};
      vecs[3]  = '{16'h1235, 1'b0, 1'b0, 4'hF, 16'h0F12, 3, 0, 2, 1'b0, 1'b0, 1'b0,     8'hFF, 1'b0};
      vecs[4]  = '{16'h1234, 1'b0, 1'b1, 4'h3, 16'h0F02, 0, 0, 0, 1'b1, 1'b0, 1'b0,     8'h30, 1'b1};
      vecs[5]  = '{16'h7FFF, 1'b1, 1'b1, 4'hA, 16'h8001, 0, 2, 1, 1'b0, 1'b0, 1'b0,     8'h80, 1'b0};
      vecs[6]  = '{16'h0000, 1'b0, 1'b0, 4'h7, 16'hFFF0, 0, 0, 0, 1'b0, 1'b0, 1'b0,     8'h70, 1'b1};
      vecs[7]  = '{16'h3000, 1'b0, 1'b0, 4'h1, 16'h0004, 1, 0, 0, 1'b0, 1'b1, 1'b0,     8'h14, 1'b0};
      vecs[8]  = '{16'h3001, 1'b1, 1'b0, 4'h0, 16'h9900, 0, 1, 0, 1'b0, 1'b0, 1'b0,     8'h99, 1'b0};
      vecs[9]  = '{16'h3000, 1'b0, 1'b1, 4'h2, 16'h9900, 0, 0, 0, 1'b0, 1'b0, CACHE_ON, 8'h20, 1'b1};
      vecs[10] = '{16'h2222, 1'b1, 1'b0, 4'h0, 16'h00AB, 0, 0, 0, 1'b0, 1'b0, 1'b0,     8'hAB, 1'b0};

      // Reset state.
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_vram_req", {31'd0, vram_req}, 32'd0);
      chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst_vram_addr", {17'd0, vram_addr}, 32'd0);
      step();
      reset_N = 1'b1;
      #1;
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      step();

      for (int i = 0; i < 11; i++) run_txn(i, vecs[i]);

      // Reset dropped while waiting for read data, late rvalid must be dropped.
      in_valid = 1'b1; in_addr = 16'h4444; in_palettemode = 1'b0;
      in_nibble_sel = 1'b0; in_palbank = 4'h9;
      step();
      in_valid = 1'b0;
      chk("mid_req", {31'd0, vram_req}, 32'd1);
      vram_gnt = 1'b1;
      step();
      vram_gnt = 1'b0;
      chk("mid_wait_req", {31'd0, vram_req}, 32'd0);
      reset_N = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_req", {31'd0, vram_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, pix_valid}, 32'd0);
      chk("mid_rst_index", {24'd0, pix_index}, 32'd0);
      chk("mid_rst_transp", {31'd0, pix_transparent}, 32'd0);
      chk("mid_rst_addr", {17'd0, vram_addr}, 32'd0);
      vram_rvalid = 1'b1; vram_rdata = 16'h5555;
      step();
      step();
      reset_N = 1'b1;
      step();
      vram_rvalid = 1'b0; vram_rdata = 16'hDEAD;
      chk("late_valid", {31'd0, pix_valid}, 32'd0);
      chk("late_req", {31'd0, vram_req}, 32'd0);
      step();
      chk("late_valid2", {31'd0, pix_valid}, 32'd0);
      vr = vecs[10];
      vr.hit = 1'b0;
      run_txn(11, vr);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
